decay_scheduler: RTL and testbench

Timestep sequencer for the shared potential-decay unit. On each timestep pulse it sweeps every neuron address. For each address it reads the membrane potential from potential memory, issues it to the decay unit with the global model and decay rate, waits for the result, and writes it back. While the sweep runs it holds the potential-adder write port off so that no read-modify-write hazard can occur.

---
 rtl/decay_scheduler.sv | 161 ++++++++++++++++
 tb/tb_decay_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decay_scheduler.sv
// Timestep sequencer: sweeps every neuron through the shared decay unit and writes results back.
// Optional DECAY_SKIP_ZERO_EN bypasses the decay unit and write-back for +/-0.0 potentials.
module decay_scheduler #(
   parameter int unsigned NEURON_COUNT = 64,
   parameter int unsigned ADDR_W       = 12
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              timestep,
   input  logic [1:0]        cfg_model,
   input  logic [3:0]        cfg_decay_rate,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wr_data,
   input  logic [31:0]       mem_rd_data,
   output logic              dec_start,
   output logic [31:0]       dec_potential,
   output logic [1:0]        dec_model,
   output logic [3:0]        dec_decay_rate,
   input  logic              dec_done,
   input  logic [31:0]       dec_result,
   input  logic              acc_req,
   output logic              acc_gnt,
   output logic              busy,
   output logic              sweep_done,
   output logic              ts_overrun
);

   localparam int unsigned     DATA_W    = 32;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEURON_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   pot_q, pot_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [1:0]          model_q, model_d;
   logic [3:0]          rate_q, rate_d;
   logic                ovr_q, ovr_d;
   logic                is_last;
   logic                skip_zero;

   assign is_last = (addr_q == LAST_ADDR);

`ifdef DECAY_SKIP_ZERO_EN
   assign skip_zero = (mem_rd_data[30:0] == 31'd0);
`else
   assign skip_zero = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (timestep) state_d = S_READ;
         S_READ:  state_d = S_ISSUE;
         S_ISSUE: begin
            if (skip_zero) state_d = is_last ? S_DONE : S_READ;
            else           state_d = S_WAIT;
         end
         S_WAIT:  if (dec_done) state_d = S_WRITE;
         S_WRITE: state_d = is_last ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers: address, operand, result, latched config, overrun flag
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         addr_q  <= '0;
         pot_q   <= '0;
         res_q   <= '0;
         model_q <= '0;
         rate_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         pot_q   <= pot_d;
         res_q   <= res_d;
         model_q <= model_d;
         rate_q  <= rate_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      addr_d  = addr_q;
      pot_d   = pot_q;
      res_d   = res_q;
      model_d = model_q;
      rate_d  = rate_q;
      ovr_d   = ovr_q | (timestep & (state_q != S_IDLE));
      unique case (state_q)
         S_IDLE: begin
            if (timestep) begin
               addr_d  = '0;
               model_d = cfg_model;
               rate_d  = cfg_decay_rate;
            end
         end
         S_ISSUE: begin
            pot_d = mem_rd_data;
            if (skip_zero && !is_last) addr_d = addr_q + ADDR_W'(1);
         end
         S_WAIT: begin
            if (dec_done) res_d = dec_result;
         end
         S_WRITE: begin
            if (!is_last) addr_d = addr_q + ADDR_W'(1);
         end
         default: ;
      endcase
   end

   // Outputs decoded from state; operand passes through during ISSUE so it is valid with dec_start
   always_comb begin
      mem_rd_en      = 1'b0;
      mem_wr_en      = 1'b0;
      dec_start      = 1'b0;
      sweep_done     = 1'b0;
      busy           = (state_q != S_IDLE);
      acc_gnt        = 1'b0;
      mem_addr       = addr_q;
      mem_wr_data    = res_q;
      dec_potential  = pot_q;
      dec_model      = model_q;
      dec_decay_rate = rate_q;
      ts_overrun     = ovr_q;
      unique case (state_q)
         S_IDLE:  acc_gnt = RESETn & acc_req & ~timestep;
         S_READ:  mem_rd_en = 1'b1;
         S_ISSUE: begin
            dec_potential = mem_rd_data;
            dec_start     = ~skip_zero;
         end
         S_WRITE: mem_wr_en = 1'b1;
         S_DONE:  sweep_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_decay_scheduler.sv
// Bench for decay_scheduler: memory and decay-unit models, scoreboard of expected writes and
// sweep_done events with their cycle numbers.
module tb_decay_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 12;
`ifdef DECAY_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESETn;
   logic          timestep;
   logic [1:0]    cfg_model;
   logic [3:0]    cfg_decay_rate;
   logic          mem_rd_en, mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wr_data;
   logic [31:0]   mem_rd_data = 32'd0;
   logic          dec_start;
   logic [31:0]   dec_potential;
   logic [1:0]    dec_model;
   logic [3:0]    dec_decay_rate;
   logic          dec_done;
   logic [31:0]   dec_result;
   logic          acc_req, acc_gnt, busy, sweep_done, ts_overrun;
   logic          spur_done;

   decay_scheduler #(.NEURON_COUNT(N), .ADDR_W(AW)) dut (
      .CLK(CLK), .RESETn(RESETn), .timestep(timestep),
      .cfg_model(cfg_model), .cfg_decay_rate(cfg_decay_rate),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
      .dec_start(dec_start), .dec_potential(dec_potential), .dec_model(dec_model),
      .dec_decay_rate(dec_decay_rate), .dec_done(dec_done), .dec_result(dec_result),
      .acc_req(acc_req), .acc_gnt(acc_gnt), .busy(busy), .sweep_done(sweep_done),
      .ts_overrun(ts_overrun)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int ds_cnt = 0;
   bit win_en = 1'b0;
   int win_t  = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] half(input logic [31:0] x);
      return (x[30:23] == 8'd0) ? x : x - 32'h0080_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Potential memory: one-cycle read latency
   logic [31:0] mem     [N];
   logic [31:0] ref_mem [N];
   always @(posedge CLK) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr[1:0]];
      if (mem_wr_en) mem[mem_addr[1:0]] <= mem_wr_data;
   end

   // Decay unit: result = operand / 2, dec_done two cycles after dec_start
   int          dcnt = 0;
   logic [31:0] dop  = 32'd0;
   always @(posedge CLK) begin
      if (dec_start) begin
         dcnt <= 2;
         dop  <= dec_potential;
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
      end
   end
   assign dec_done   = (dcnt == 1) | spur_done;
   assign dec_result = half(dop);

   typedef struct {
      logic        done;
      logic [31:0] data;
      logic [11:0] addr;
      int          cyc;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   // Output monitor
   always @(negedge CLK) begin
      if (RESETn) begin
         if (dec_start) ds_cnt++;
         if (busy && dcnt > 0) check_eq("pot_hold", dec_potential, dop);
         if (mem_wr_en || sweep_done) begin
            if (q.size() == 0) begin
               check_eq("unexpected_evt", {mem_wr_en, sweep_done}, 2'b00);
            end else begin
               mon_e = q.pop_front();
               if (mon_e.done)
                  check_eq("done_evt", {mem_wr_en, sweep_done}, 2'b01);
               else
                  check_eq("wr_evt", {mem_wr_en, sweep_done, mem_addr, mem_wr_data},
                           {2'b10, mon_e.addr, mon_e.data});
               check_eq("evt_cycle", mon_e.cyc, cyc);
            end
         end
         if (win_en) begin
            check_eq("busy_win", busy, (cyc >= win_t + 1) && (cyc <= win_t + 21));
            check_eq("gnt_win", acc_gnt, !((cyc >= win_t) && (cyc <= win_t + 21)));
            if (busy) check_eq("rate_hold", {dec_model, dec_decay_rate}, {2'b01, 4'b0010});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_sweep(input int t);
      int cur;
      cur = t + 1;
      for (int i = 0; i < N; i++) begin
         if (SKIP && ref_mem[i][30:0] == 31'd0) begin
            cur += 2;
         end else begin
            q.push_back('{done: 1'b0, data: half(ref_mem[i]), addr: 12'(i), cyc: cur + 4});
            ref_mem[i] = half(ref_mem[i]);
            cur += 5;
         end
      end
      q.push_back('{done: 1'b1, data: 32'd0, addr: 12'd0, cyc: cur});
   endtask

   task automatic start_sweep(input bit win, output int t);
      tick();
      timestep = 1'b1;
      t        = cyc;
      ds_cnt   = 0;
      if (win) begin
         win_t  = t;
         win_en = 1'b1;
      end
      push_sweep(t);
      tick();
      timestep = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) tick();
      check_eq("drain_timeout", q.size(), 0);
   endtask

   task automatic preload(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
      mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3;
      ref_mem[0] = v0; ref_mem[1] = v1; ref_mem[2] = v2; ref_mem[3] = v3;
   endtask

   localparam logic [31:0] TEN = 32'h4120_0000;

   initial begin
      int  t;
      bit  found;
      RESETn = 1'b1; timestep = 1'b0; acc_req = 1'b1; spur_done = 1'b0;
      cfg_model = 2'b01; cfg_decay_rate = 4'b0010;
      preload(TEN, TEN, TEN, TEN);
      #2 RESETn = 1'b0;
      tick(); tick();
      check_eq("reset_outs",
               {mem_rd_en, mem_wr_en, mem_addr, dec_start, dec_model, dec_decay_rate,
                acc_gnt, busy, sweep_done, ts_overrun}, 64'd0);
      check_eq("reset_data", {mem_wr_data, dec_potential}, 64'd0);
      tick();
      RESETn = 1'b1;
      tick();
      check_eq("idle_gnt", {busy, acc_gnt}, 2'b01);
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      tick();
      check_eq("spur_done_ignored", {busy, mem_wr_en, sweep_done}, 3'b000);

      // Basic sweep with acc_req held and config changed mid-sweep
      start_sweep(1'b1, t);
      repeat (7) tick();
      cfg_decay_rate = 4'b0100;
      cfg_model      = 2'b10;
      wait_drain(60);
      repeat (3) tick();
      win_en = 1'b0;
      check_eq("ds_cnt_a", ds_cnt, N);
      for (int i = 0; i < N; i++) check_eq("mem_a", mem[i], 32'h40A0_0000);
      check_eq("cfg_after_a", {dec_model, dec_decay_rate}, {2'b01, 4'b0010});

      // Overrun: second timestep mid-sweep is dropped and flagged
      acc_req = 1'b0;
      preload(TEN, 32'h4200_0000, 32'hC040_0000, 32'h3F80_0000);
      check_eq("ovr_clear", ts_overrun, 1'b0);
      start_sweep(1'b0, t);
      repeat (4) tick();
      timestep = 1'b1;
      @(negedge CLK);
      check_eq("ovr_same_cycle", ts_overrun, 1'b0);
      tick();
      timestep = 1'b0;
      @(negedge CLK);
      check_eq("ovr_next_cycle", ts_overrun, 1'b1);
      wait_drain(60);
      repeat (8) tick();
      check_eq("ovr_no_extra", {busy, ts_overrun}, 2'b01);
      check_eq("ds_cnt_b", ds_cnt, N);
      check_eq("cfg_b", {dec_model, dec_decay_rate}, {2'b10, 4'b0100});

      // Zero potentials
      preload(32'd0, TEN, 32'd0, 32'h8000_0000);
      start_sweep(1'b0, t);
      wait_drain(60);
      repeat (3) tick();
      check_eq("ds_cnt_zero", ds_cnt, SKIP ? 1 : N);
      check_eq("mem_zero_1", mem[1], 32'h40A0_0000);

      // Reset during WAIT of address 2
      preload(TEN, TEN, TEN, TEN);
      start_sweep(1'b0, t);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         if (dec_start && mem_addr == AW'(2)) found = 1'b1;
      end
      check_eq("found_addr2", found, 1'b1);
      tick();
      RESETn = 1'b0;
      #1;
      check_eq("abort_outs",
               {mem_rd_en, mem_wr_en, mem_addr, dec_start, dec_model, dec_decay_rate,
                busy, sweep_done, ts_overrun}, 64'd0);
      check_eq("abort_data", {mem_wr_data, dec_potential}, 64'd0);
      q.delete();
      repeat (3) tick();
      check_eq("no_wb_addr2", mem[2], TEN);
      RESETn = 1'b1;
      ref_mem[0] = 32'h40A0_0000; ref_mem[1] = 32'h40A0_0000;
      ref_mem[2] = TEN;           ref_mem[3] = TEN;
      tick();
      start_sweep(1'b0, t);
      wait_drain(60);
      repeat (3) tick();
      check_eq("restart_mem", {mem[0], mem[1]}, {32'h4020_0000, 32'h4020_0000});
      check_eq("restart_mem_hi", {mem[2], mem[3]}, {32'h40A0_0000, 32'h40A0_0000});
      check_eq("ovr_after_reset", ts_overrun, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim did not finish");
      $fatal(1);
   end

endmodule
